// File: rtl/step_phase_decoder.sv
// Receive-side monitor for the stepper coil-phase bus.
// Decodes the one-hot phase pattern into step events, direction, position and step period.

module step_phase_decoder #(
    parameter int unsigned POS_WIDTH     = 16,
    parameter int unsigned PERIOD_WIDTH  = 24,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [3:0]              phases,
    input  logic                    clearFault,
    input  logic                    clearPosition,
    output logic                    stepPulse,
    output logic                    direction,
    output logic [POS_WIDTH-1:0]    position,
    output logic [PERIOD_WIDTH-1:0] stepPeriod,
    output logic                    idle,
    output logic                    fault,
    output logic [1:0]              faultCode
);

    localparam int unsigned CNT_WIDTH = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(STABLE_CYCLES);
    localparam logic [PERIOD_WIDTH-1:0] PER_MAX = '1;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_TRACKING = 2'd1;
    localparam logic [1:0] ST_FAULT    = 2'd2;

    localparam logic [1:0] CODE_NONE    = 2'b00;
    localparam logic [1:0] CODE_ILLEGAL = 2'b01;
    localparam logic [1:0] CODE_SKIP    = 2'b10;

    // Input conditioning
    logic [3:0]           sync1_q, sync2_q, hold_q;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 changed;
    logic                 acc_d, acc_q;
    logic [3:0]           acc_pat_q;

    // Decode and control
    logic [1:0]              state_q, state_d;
    logic [1:0]              last_q, last_d;
    logic                    acc_legal, acc_off;
    logic [1:0]              acc_idx;
    logic [1:0]              step_diff;
    logic                    step;
    logic                    enter;
    logic                    dir_d;
    logic [1:0]              code_d;
    logic [POS_WIDTH-1:0]    pos_d;
    logic [PERIOD_WIDTH-1:0] per_cnt_q, per_cnt_d;

    // Acceptance fires once when the hold count first reaches its limit for an appearance.
    always_comb begin
        changed = (sync2_q != hold_q);
        cnt_d   = cnt_q;
        if (changed) begin
            cnt_d = CNT_WIDTH'(1);
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
        acc_d = (cnt_d == CNT_MAX) && (changed || (cnt_q != CNT_MAX));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q   <= 4'b0000;
            sync2_q   <= 4'b0000;
            hold_q    <= 4'b0000;
            cnt_q     <= '0;
            acc_q     <= 1'b0;
            acc_pat_q <= 4'b0000;
        end else begin
            sync1_q <= phases;
            sync2_q <= sync1_q;
            hold_q  <= sync2_q;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            if (acc_d) begin
                acc_pat_q <= sync2_q;
            end
        end
    end

    always_comb begin
        acc_legal = 1'b1;
        acc_off   = 1'b0;
        acc_idx   = 2'd0;
        unique case (acc_pat_q)
            4'b0001: acc_idx = 2'd0;
            4'b0010: acc_idx = 2'd1;
            4'b0100: acc_idx = 2'd2;
            4'b1000: acc_idx = 2'd3;
            4'b0000: begin
                acc_legal = 1'b0;
                acc_off   = 1'b1;
            end
            default: acc_legal = 1'b0;
        endcase
        step_diff = acc_idx - last_q;
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        step    = 1'b0;
        enter   = 1'b0;
        dir_d   = direction;
        code_d  = faultCode;
        unique case (state_q)
            ST_IDLE: begin
                if (acc_q) begin
                    if (acc_legal) begin
                        state_d = ST_TRACKING;
                        last_d  = acc_idx;
                        enter   = 1'b1;
                    end else if (!acc_off) begin
                        state_d = ST_FAULT;
                        code_d  = CODE_ILLEGAL;
                    end
                end
            end
            ST_TRACKING: begin
                if (acc_q) begin
                    if (acc_off) begin
                        state_d = ST_IDLE;
                    end else if (!acc_legal) begin
                        state_d = ST_FAULT;
                        code_d  = CODE_ILLEGAL;
                    end else begin
                        unique case (step_diff)
                            2'd1: begin
                                step   = 1'b1;
                                dir_d  = 1'b1;
                                last_d = acc_idx;
                            end
                            2'd3: begin
                                step   = 1'b1;
                                dir_d  = 1'b0;
                                last_d = acc_idx;
                            end
                            2'd2: begin
                                state_d = ST_FAULT;
                                code_d  = CODE_SKIP;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ST_FAULT: begin
                // Decoding is frozen here; only a clear leaves this state.
                if (clearFault) begin
                    state_d = ST_IDLE;
                    code_d  = CODE_NONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pos_d = position;
        if (clearPosition) begin
            pos_d = '0;
        end else if (step) begin
            pos_d = dir_d ? position + POS_WIDTH'(1) : position - POS_WIDTH'(1);
        end
    end

    always_comb begin
        per_cnt_d = per_cnt_q;
        if (step || enter) begin
            per_cnt_d = PERIOD_WIDTH'(1);
        end else if ((state_q == ST_TRACKING) && (per_cnt_q != PER_MAX)) begin
            per_cnt_d = per_cnt_q + PERIOD_WIDTH'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            last_q     <= 2'd0;
            per_cnt_q  <= '0;
            stepPulse  <= 1'b0;
            direction  <= 1'b0;
            position   <= '0;
            stepPeriod <= '0;
            idle       <= 1'b1;
            fault      <= 1'b0;
            faultCode  <= CODE_NONE;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            per_cnt_q <= per_cnt_d;
            stepPulse <= step;
            direction <= dir_d;
            position  <= pos_d;
            if (step) begin
                stepPeriod <= per_cnt_q;
            end
            idle      <= (state_d == ST_IDLE);
            fault     <= (state_d == ST_FAULT);
            faultCode <= code_d;
        end
    end

endmodule

// File: tb/tb_step_phase_decoder.sv
// Bench for step_phase_decoder: directed scenarios plus a random phase walk,
// checked every cycle against an event-level model of the decoder.

module tb_step_phase_decoder;

    localparam int unsigned POS_W = 8;
    localparam int unsigned PER_W = 10;
    localparam int PER_SAT = 1023;
    localparam int LATENCY = 6;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [3:0]       phases = 4'b0000;
    logic             clearFault = 1'b0;
    logic             clearPosition = 1'b0;
    logic             stepPulse;
    logic             direction;
    logic [POS_W-1:0] position;
    logic [PER_W-1:0] stepPeriod;
    logic             idle;
    logic             fault;
    logic [1:0]       faultCode;

    step_phase_decoder #(
        .POS_WIDTH    (POS_W),
        .PERIOD_WIDTH (PER_W),
        .STABLE_CYCLES(4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .phases       (phases),
        .clearFault   (clearFault),
        .clearPosition(clearPosition),
        .stepPulse    (stepPulse),
        .direction    (direction),
        .position     (position),
        .stepPeriod   (stepPeriod),
        .idle         (idle),
        .fault        (fault),
        .faultCode    (faultCode)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int failed = 0;
    int cyc = 0;

    // Model: what the decoder should report, updated per accepted pattern.
    bit m_track, m_fault, m_dir, m_pulse;
    int m_last, m_pos, m_per, m_code, m_ref;

    typedef struct {
        int         due;
        logic [3:0] pat;
    } ev_t;
    ev_t evq[$];

    logic [3:0] last_applied = 4'b0000;
    int  run_start = 0;
    int  run_len = 100;
    bit  run_pushed = 1'b1;
    bit  clrf_next = 1'b0;
    bit  clrp_next = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // -1: motor off, -2: illegal, else phase index.
    function automatic int pidx(input logic [3:0] p);
        case (p)
            4'b0001: return 0;
            4'b0010: return 1;
            4'b0100: return 2;
            4'b1000: return 3;
            4'b0000: return -1;
            default: return -2;
        endcase
    endfunction

    task automatic do_step(input int n, input bit fwd);
        m_pulse = 1'b1;
        m_dir   = fwd;
        m_pos   = fwd ? (m_pos + 1) % 256 : (m_pos + 255) % 256;
        m_per   = (cyc - m_ref > PER_SAT) ? PER_SAT : cyc - m_ref;
        m_ref   = cyc;
        m_last  = n;
    endtask

    task automatic model_accept(input logic [3:0] p);
        int n = pidx(p);
        int d;
        if (!m_track) begin
            if (n >= 0) begin
                m_track = 1'b1;
                m_last  = n;
                m_ref   = cyc;
            end else if (n == -2) begin
                m_fault = 1'b1;
                m_code  = 1;
            end
        end else if (n == -1) begin
            m_track = 1'b0;
        end else if (n == -2) begin
            m_track = 1'b0;
            m_fault = 1'b1;
            m_code  = 1;
        end else begin
            d = (n - m_last + 4) % 4;
            if (d == 1) do_step(n, 1'b1);
            else if (d == 3) do_step(n, 1'b0);
            else if (d == 2) begin
                m_track = 1'b0;
                m_fault = 1'b1;
                m_code  = 2;
            end
        end
    endtask

    task automatic check_all();
        chk("stepPulse", 32'(stepPulse), 32'(m_pulse));
        chk("direction", 32'(direction), 32'(m_dir));
        chk("position", 32'(position), 32'(m_pos));
        chk("stepPeriod", 32'(stepPeriod), 32'(m_per));
        chk("idle", 32'(idle), 32'(!m_track && !m_fault));
        chk("fault", 32'(fault), 32'(m_fault));
        chk("faultCode", 32'(faultCode), 32'(m_code));
    endtask

    task automatic tick();
        bit was_fault;
        ev_t ev;
        clearFault    = clrf_next;
        clearPosition = clrp_next;
        clrf_next = 1'b0;
        clrp_next = 1'b0;
        @(posedge clock);
        cyc++;
        m_pulse   = 1'b0;
        was_fault = m_fault;
        if (was_fault && clearFault) begin
            m_fault = 1'b0;
            m_code  = 0;
        end
        while (evq.size() > 0 && evq[0].due <= cyc) begin
            ev = evq.pop_front();
            if (!was_fault) model_accept(ev.pat);
        end
        if (clearPosition) m_pos = 0;
        @(negedge clock);
        clearFault    = 1'b0;
        clearPosition = 1'b0;
        check_all();
    endtask

    // Drive a pattern for n cycles; a run of 4+ cycles is accepted LATENCY edges after it began.
    task automatic hold(input logic [3:0] p, input int n);
        phases = p;
        if (p != last_applied) begin
            run_start  = cyc + 1;
            run_len    = 0;
            run_pushed = 1'b0;
        end
        last_applied = p;
        run_len += n;
        if (!run_pushed && run_len >= 4) begin
            evq.push_back('{due: run_start + LATENCY, pat: p});
            run_pushed = 1'b1;
        end
        repeat (n) tick();
    endtask

    task automatic do_reset();
        #2;
        reset  = 1'b0;
        phases = 4'b0000;
        #1;
        chk("rst_stepPulse", 32'(stepPulse), 32'd0);
        chk("rst_direction", 32'(direction), 32'd0);
        chk("rst_position", 32'(position), 32'd0);
        chk("rst_stepPeriod", 32'(stepPeriod), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_faultCode", 32'(faultCode), 32'd0);
        m_track = 0; m_fault = 0; m_dir = 0; m_pulse = 0;
        m_last = 0; m_pos = 0; m_per = 0; m_code = 0; m_ref = 0;
        evq.delete();
        last_applied = 4'b0000;
        run_pushed   = 1'b1;
        @(posedge clock);
        cyc++;
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        logic [3:0] p;
        int cur;
        int r;

        do_reset();
        repeat (8) tick();

        // Forward rotation
        hold(4'b0001, 20);
        hold(4'b0010, 20);
        hold(4'b0100, 20);
        hold(4'b1000, 20);
        hold(4'b0001, 20);
        chk("fwd_position", 32'(position), 32'd4);
        chk("fwd_period", 32'(stepPeriod), 32'd20);
        chk("fwd_direction", 32'(direction), 32'd1);

        // Motor off keeps position
        hold(4'b0000, 12);
        chk("off_idle", 32'(idle), 32'd1);
        chk("off_position", 32'(position), 32'd4);

        // Reverse from zero
        clrp_next = 1'b1;
        tick();
        hold(4'b0001, 20);
        hold(4'b1000, 20);
        hold(4'b0100, 20);
        chk("rev_position", 32'(position), 32'hFE);
        chk("rev_direction", 32'(direction), 32'd0);
        clrp_next = 1'b1;
        tick();
        tick();
        chk("clr_position", 32'(position), 32'd0);

        // Skip, frozen fault, clear, illegal
        hold(4'b0000, 12);
        hold(4'b0001, 12);
        hold(4'b0100, 12);
        hold(4'b1000, 12);
        hold(4'b0001, 12);
        chk("skip_fault", 32'(fault), 32'd1);
        chk("skip_code", 32'(faultCode), 32'd2);
        clrf_next = 1'b1;
        tick();
        tick();
        chk("clrf_idle", 32'(idle), 32'd1);
        chk("clrf_code", 32'(faultCode), 32'd0);
        hold(4'b0011, 12);
        chk("illegal_code", 32'(faultCode), 32'd1);
        clrf_next = 1'b1;
        tick();
        hold(4'b0000, 12);

        // Glitches in tracking
        hold(4'b0001, 12);
        hold(4'b0010, 3);
        hold(4'b0001, 12);
        hold(4'b0010, 4);
        hold(4'b0001, 12);

        // Wrap at the signed boundary
        clrp_next = 1'b1;
        tick();
        for (int i = 1; i <= 128; i++) begin
            p = 4'b0001 << (i % 4);
            hold(p, 8);
        end
        chk("wrap_position", 32'(position), 32'h80);

        // Clear coincident with a step
        hold(4'b0010, 6);
        clrp_next = 1'b1;
        hold(4'b0010, 6);
        chk("clr_step_position", 32'(position), 32'd0);

        // Period saturation on a long hold
        hold(4'b0100, 1100);
        hold(4'b1000, 10);
        chk("sat_period", 32'(stepPeriod), 32'h3FF);

        // Random phase walk
        cur = 3;
        for (int it = 0; it < 300; it++) begin
            r = int'($urandom_range(0, 19));
            if (r == 0) begin
                p = 4'b0000;
            end else if (r == 1) begin
                do p = 4'($urandom_range(0, 15)); while (pidx(p) != -2);
            end else if (r == 2) begin
                cur = (cur + 2) % 4;
                p = 4'b0001 << cur;
            end else begin
                cur = (r % 2 == 1) ? (cur + 1) % 4 : (cur + 3) % 4;
                p = 4'b0001 << cur;
            end
            hold(p, int'($urandom_range(8, 25)));
            if (m_fault && $urandom_range(0, 1) == 1) begin
                clrf_next = 1'b1;
                tick();
            end
            if ($urandom_range(0, 15) == 0) begin
                clrp_next = 1'b1;
                tick();
            end
        end
        if (m_fault) begin
            clrf_next = 1'b1;
            tick();
        end

        // Asynchronous reset while a step is in flight
        hold(4'b0000, 10);
        hold(4'b0001, 10);
        hold(4'b0010, 4);
        do_reset();
        repeat (8) tick();
        hold(4'b0100, 12);
        hold(4'b1000, 12);
        chk("post_rst_position", 32'(position), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
